// File: rtl/carrier_lock_ctrl_if.sv
// Signal bundle for carrier_lock_ctrl: phase-detector sample stream in, loop-control outputs out.
interface carrier_lock_ctrl_if;
    logic signed [25:0] pd;
    logic               sym_en;
    logic               restart;
    logic [1:0]         gain_sel;
    logic               lock;
    logic               nco_clr;
    logic [1:0]         state;
    logic signed [15:0] sweep;

    modport master (
        output pd, sym_en, restart,
        input  gain_sel, lock, nco_clr, state, sweep
    );

    modport slave (
        input  pd, sym_en, restart,
        output gain_sel, lock, nco_clr, state, sweep
    );
endinterface

// File: rtl/carrier_lock_ctrl.sv
// Carrier lock detector: windowed |pd| average drives ACQ/CONFIRM/LOCKED loop-gain control.
// Define CARRIER_SWEEP_EN to enable the triangle frequency sweep on acquisition timeouts.
module carrier_lock_ctrl #(
    parameter int unsigned WIN        = 10,
    parameter logic [24:0] LOCK_TH    = 25'd40000,
    parameter logic [24:0] UNLOCK_TH  = 25'd120000,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned ACQ_TO     = 16
) (
    input logic                clk,
    input logic                rst,
    carrier_lock_ctrl_if.slave bus
);
    localparam int unsigned AW = 25 + WIN;
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned TW = $clog2(ACQ_TO + 1);
    // Thresholds scaled by the window length so the average needs no divider.
    localparam logic [AW-1:0] LockLim   = {{WIN{1'b0}}, LOCK_TH} << WIN;
    localparam logic [AW-1:0] UnlockLim = {{WIN{1'b0}}, UNLOCK_TH} << WIN;

    typedef enum logic [1:0] {StAcq = 2'd0, StConfirm = 2'd1, StLocked = 2'd2} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [WIN-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]   good_q, good_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic [TW-1:0]   to_q, to_d;
    logic [1:0]      gain_q, gain_d;
    logic            lock_q, lock_d;
    logic            nco_q, nco_d;

    logic signed [25:0] pd_neg;
    logic [24:0]        mag;
    logic [AW-1:0]      avg_sum;
    logic               win_end, good, bad;

    assign pd_neg = -bus.pd;

    // -2^25 has no positive 26-bit counterpart, so it saturates to 2^25-1.
    always_comb begin
        if (!bus.pd[25]) begin
            mag = bus.pd[24:0];
        end else if (bus.pd[24:0] == 25'd0) begin
            mag = '1;
        end else begin
            mag = pd_neg[24:0];
        end
    end

    assign win_end = bus.sym_en && (cnt_q == '1);
    assign avg_sum = acc_q + {{WIN{1'b0}}, mag};
    assign good    = avg_sum < LockLim;
    assign bad     = avg_sum > UnlockLim;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        miss_d  = miss_q;
        to_d    = to_q;
        nco_d   = 1'b0;

        if (bus.sym_en) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = win_end ? '0 : avg_sum;
        end

        if (win_end) begin
            unique case (state_q)
                StAcq: begin
                    if (good) begin
                        good_d  = GW'(1);
                        state_d = StConfirm;
                    end else if (to_q == TW'(ACQ_TO - 1)) begin
                        to_d  = '0;
                        nco_d = 1'b1;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                StConfirm: begin
                    if (!good) begin
                        state_d = StAcq;
                        good_d  = '0;
                        to_d    = '0;
                    end else if (good_q == GW'(LOCK_CNT - 1)) begin
                        state_d = StLocked;
                        good_d  = '0;
                        miss_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                StLocked: begin
                    if (!bad) begin
                        miss_d = '0;
                    end else if (miss_q == MW'(UNLOCK_CNT - 1)) begin
                        state_d = StAcq;
                        miss_d  = '0;
                        to_d    = '0;
                        nco_d   = 1'b1;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
                default: state_d = StAcq;
            endcase
        end

        // Restart wins over a coincident window end.
        if (bus.restart) begin
            state_d = StAcq;
            acc_d   = '0;
            cnt_d   = '0;
            good_d  = '0;
            miss_d  = '0;
            to_d    = '0;
            nco_d   = 1'b0;
        end

        gain_d = 2'd0;
        lock_d = 1'b0;
        unique case (state_d)
            StConfirm: gain_d = 2'd1;
            StLocked: begin
                gain_d = 2'd2;
                lock_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StAcq;
            acc_q   <= '0;
            cnt_q   <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            to_q    <= '0;
            gain_q  <= 2'd0;
            lock_q  <= 1'b0;
            nco_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            to_q    <= to_d;
            gain_q  <= gain_d;
            lock_q  <= lock_d;
            nco_q   <= nco_d;
        end
    end

`ifdef CARRIER_SWEEP_EN
    logic signed [15:0] sweep_q, step_q;
    logic signed [16:0] sweep_try;
    logic               timeout;

    // In ACQ the only source of an nco_clr pulse is the acquisition timeout.
    assign timeout   = nco_d && (state_q == StAcq);
    assign sweep_try = $signed({sweep_q[15], sweep_q}) + $signed({step_q[15], step_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_q <= '0;
            step_q  <= 16'sd512;
        end else if (bus.restart) begin
            sweep_q <= '0;
            step_q  <= 16'sd512;
        end else if (timeout) begin
            if (sweep_try > 17'sd8192 || sweep_try < -17'sd8192) begin
                step_q  <= -step_q;
                sweep_q <= sweep_q - step_q;
            end else begin
                sweep_q <= sweep_try[15:0];
            end
        end
    end

    assign bus.sweep = sweep_q;
`else
    assign bus.sweep = '0;
`endif

    assign bus.state    = state_q;
    assign bus.gain_sel = gain_q;
    assign bus.lock     = lock_q;
    assign bus.nco_clr  = nco_q;

endmodule

// File: tb/tb_carrier_lock_ctrl.sv
// Scoreboard bench for carrier_lock_ctrl with WIN=4, ACQ_TO=2 and sym_en on every 4th clock.
module tb_carrier_lock_ctrl;
    localparam logic [1:0] StAcq     = 2'd0;
    localparam logic [1:0] StConfirm = 2'd1;
    localparam logic [1:0] StLocked  = 2'd2;
    localparam logic signed [25:0] PdGood = 26'sd1000;
    localparam logic signed [25:0] PdBad  = -26'sd200000;
    localparam logic signed [25:0] PdMid  = 26'sd90000;
    localparam logic signed [25:0] PdSat  = 26'sh2000000;

    typedef struct {
        logic [1:0]         st;
        logic [1:0]         gs;
        logic               lk;
        int                 nco;
        logic signed [15:0] sw;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   win_id;
    exp_t sb[$];

    carrier_lock_ctrl_if bus ();

    carrier_lock_ctrl #(
        .WIN       (4),
        .LOCK_CNT  (4),
        .UNLOCK_CNT(3),
        .ACQ_TO    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got hang, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_win(input logic [1:0] st, input logic [1:0] gs, input logic lk,
                              input int nco, input logic signed [15:0] sw);
        exp_t e;
        e.st  = st;
        e.gs  = gs;
        e.lk  = lk;
        e.nco = nco;
        e.sw  = sw;
        sb.push_back(e);
    endtask

    // One full 16-symbol window; outputs are checked one clock after its final sym_en.
    task automatic send_window(input logic signed [25:0] p, input bit rs);
        exp_t e;
        int   nco_seen;
        nco_seen = 0;
        win_id++;
        e.st = 2'd0; e.gs = 2'd0; e.lk = 1'b0; e.nco = 0; e.sw = '0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                bus.pd      = p;
                bus.sym_en  = (k == 0);
                bus.restart = rs && (i == 15) && (k == 0);
                @(posedge clk);
                #1;
                bus.sym_en  = 1'b0;
                bus.restart = 1'b0;
                if (bus.nco_clr === 1'b1) nco_seen++;
                if (i == 15 && k == 0) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard win %0d: got empty queue, want entry", win_id);
                    end else begin
                        e = sb.pop_front();
                        if (bus.state !== e.st) begin
                            n_fail++;
                            $display("FAIL state win %0d: got %0d want %0d",
                                     win_id, bus.state, e.st);
                        end
                        n_checks++;
                        if (bus.gain_sel !== e.gs) begin
                            n_fail++;
                            $display("FAIL gain_sel win %0d: got %0d want %0d",
                                     win_id, bus.gain_sel, e.gs);
                        end
                        n_checks++;
                        if (bus.lock !== e.lk) begin
                            n_fail++;
                            $display("FAIL lock win %0d: got %0b want %0b",
                                     win_id, bus.lock, e.lk);
                        end
                        n_checks++;
                        if (bus.sweep !== e.sw) begin
                            n_fail++;
                            $display("FAIL sweep win %0d: got %0d want %0d",
                                     win_id, bus.sweep, e.sw);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (nco_seen != e.nco) begin
            n_fail++;
            $display("FAIL nco_clr cycles win %0d: got %0d want %0d", win_id, nco_seen, e.nco);
        end
    endtask

    task automatic send_partial(input logic signed [25:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                bus.pd     = p;
                bus.sym_en = (k == 0);
                @(posedge clk);
                #1;
                bus.sym_en = 1'b0;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (bus.state !== StAcq) begin
            n_fail++;
            $display("FAIL %s state: got %0d want 0", tag, bus.state);
        end
        n_checks++;
        if (bus.gain_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL %s gain_sel: got %0d want 0", tag, bus.gain_sel);
        end
        n_checks++;
        if (bus.lock !== 1'b0) begin
            n_fail++;
            $display("FAIL %s lock: got %0b want 0", tag, bus.lock);
        end
        n_checks++;
        if (bus.nco_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL %s nco_clr: got %0b want 0", tag, bus.nco_clr);
        end
        n_checks++;
        if (bus.sweep !== 16'sd0) begin
            n_fail++;
            $display("FAIL %s sweep: got %0d want 0", tag, bus.sweep);
        end
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        @(posedge clk);
        #1;
        bus.restart = 1'b0;
        check_idle("restart");
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.pd      = '0;
        bus.sym_en  = 1'b0;
        bus.restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
        send_window(PdGood, 1'b0);
        expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
        send_window(PdGood, 1'b0);
        expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
        send_window(PdGood, 1'b0);
        expect_win(StLocked, 2'd2, 1'b1, 0, 16'sd0);
        send_window(PdGood, 1'b0);
    endtask

    // Two misses then a good window must reset the miss count; three more misses unlock.
    task automatic test_unlock();
        for (int w = 0; w < 5; w++) begin
            expect_win(StLocked, 2'd2, 1'b1, 0, 16'sd0);
            send_window((w == 2) ? PdGood : PdBad, 1'b0);
        end
        expect_win(StAcq, 2'd0, 1'b0, 1, 16'sd0);
        send_window(PdBad, 1'b0);
    endtask

    task automatic test_timeout();
        int sw;
        int step;
        int nxt;
        sw   = 0;
        step = 512;
        for (int w = 1; w <= 36; w++) begin
            if (w % 2 == 0) begin
`ifdef CARRIER_SWEEP_EN
                nxt = sw + step;
                if (nxt > 8192 || nxt < -8192) step = -step;
                sw = sw + step;
`else
                nxt = 0;
`endif
            end
            expect_win(StAcq, 2'd0, 1'b0, (w % 2 == 0) ? 1 : 0, 16'(sw));
            send_window(PdMid, 1'b0);
        end
    endtask

    task automatic test_saturation();
        do_restart();
        for (int w = 0; w < 3; w++) begin
            expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
            send_window(PdGood, 1'b0);
        end
        expect_win(StLocked, 2'd2, 1'b1, 0, 16'sd0);
        send_window(PdGood, 1'b0);
        expect_win(StLocked, 2'd2, 1'b1, 0, 16'sd0);
        send_window(PdSat, 1'b0);
        expect_win(StLocked, 2'd2, 1'b1, 0, 16'sd0);
        send_window(PdSat, 1'b0);
        expect_win(StAcq, 2'd0, 1'b0, 1, 16'sd0);
        send_window(PdSat, 1'b0);
    endtask

    task automatic test_restart();
        do_restart();
        expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
        send_window(PdGood, 1'b0);
        expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
        send_window(PdGood, 1'b0);
        expect_win(StAcq, 2'd0, 1'b0, 0, 16'sd0);
        send_window(PdGood, 1'b1);
        // A partial window of huge samples must be discarded by a mid-window restart.
        send_partial(PdSat, 8);
        do_restart();
        for (int w = 0; w < 3; w++) begin
            expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
            send_window(PdGood, 1'b0);
        end
        expect_win(StLocked, 2'd2, 1'b1, 0, 16'sd0);
        send_window(PdGood, 1'b0);
    endtask

    task automatic test_async_reset();
        send_partial(PdSat, 5);
        #3;
        rst = 1'b0;
        #2;
        check_idle("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_hold");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
        send_window(PdGood, 1'b0);
        expect_win(StConfirm, 2'd1, 1'b0, 0, 16'sd0);
        send_window(PdGood, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        win_id   = 0;
        test_reset();
        test_lock();
        test_unlock();
        test_timeout();
        test_saturation();
        test_restart();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
